ghr_spec_ctrl: RTL and testbench

//  Controller for the global history register (GHR) feeding the tournament predictor.
//  - Shifts predicted directions into a speculative history.
//  - Queues each in-flight prediction in a checkpoint FIFO.
//  - Retires resolutions in order into a committed (architectural) history.
//  - On a mispredict, repairs the speculative history from the committed one and

---
 rtl/ghr_spec_ctrl_if.sv | 35 +++
 rtl/ghr_spec_ctrl.sv | 108 ++++++++++
 tb/tb_ghr_spec_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ghr_spec_ctrl_if.sv
// Handshake bundle between the fetch-side predictor, the branch-resolution unit
// and the GHR controller.
interface ghr_spec_ctrl_if #(
   parameter int HIST_W = 12,
   parameter int DEPTH  = 8
);
   localparam int TAG_W = $clog2(DEPTH);

   logic              pred_valid;
   logic              pred_taken;
   logic              pred_ready;
   logic [TAG_W-1:0]  pred_tag;
   logic              resolve_valid;
   logic              resolve_taken;
   logic              mispredict;
   logic [HIST_W-1:0] spec_history;
   logic [HIST_W-1:0] arch_history;
   logic [TAG_W:0]    inflight;
   logic              recovering;
   logic              err;

   // Predictor / resolution side.
   modport master (
      output pred_valid, pred_taken, resolve_valid, resolve_taken,
      input  pred_ready, pred_tag, mispredict, spec_history, arch_history,
             inflight, recovering, err
   );

   // Controller side.
   modport slave (
      input  pred_valid, pred_taken, resolve_valid, resolve_taken,
      output pred_ready, pred_tag, mispredict, spec_history, arch_history,
             inflight, recovering, err
   );
endinterface

// File: rtl/ghr_spec_ctrl.sv
// Speculative/committed global history controller with an in-order checkpoint
// FIFO and a fixed-length stall after each history repair.
module ghr_spec_ctrl #(
   parameter int HIST_W         = 12,
   parameter int DEPTH          = 8,
   parameter int RECOVER_CYCLES = 2
) (
   input  logic          clk,
   input  logic          rst,
   ghr_spec_ctrl_if.slave bus
);
   localparam int TAG_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(RECOVER_CYCLES + 1);
   localparam logic [TAG_W:0]   FULL     = (TAG_W + 1)'(DEPTH);
   localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W + 1)'(1);
   localparam logic [TAG_W-1:0] PTR_ONE  = TAG_W'(1);
   localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'(RECOVER_CYCLES);
   localparam logic [CNT_W-1:0] REC_ONE  = CNT_W'(1);

   typedef enum logic {RUN, RECOVER} state_e;

   state_e            state_q;
   logic [CNT_W-1:0]  rec_cnt_q;
   logic [TAG_W-1:0]  wptr_q, rptr_q;
   logic [TAG_W:0]    count_q;
   logic [DEPTH-1:0]  fifo_q;
   logic [HIST_W-1:0] spec_q, arch_q;
   logic              mispredict_q, err_q;

   logic accept, res_ok, res_bad, mis;

   function automatic logic [HIST_W-1:0] shl(input logic [HIST_W-1:0] h, input logic b);
      return {h[HIST_W-2:0], b};
   endfunction

   assign bus.pred_ready   = (state_q == RUN) && (count_q != FULL);
   assign bus.pred_tag     = wptr_q;
   assign bus.mispredict   = mispredict_q;
   assign bus.spec_history = spec_q;
   assign bus.arch_history = arch_q;
   assign bus.inflight     = count_q;
   assign bus.recovering   = (state_q == RECOVER);
   assign bus.err          = err_q;

   always_comb begin
      accept  = bus.pred_valid && bus.pred_ready;
      res_ok  = bus.resolve_valid && (state_q == RUN) && (count_q != '0);
      res_bad = bus.resolve_valid && !res_ok;
      mis     = res_ok && (bus.resolve_taken != fifo_q[rptr_q]);
   end

   // NOTE: checkpoint storage carries no reset; an entry is only read after it was written.
   always_ff @(posedge clk) begin
      if (accept) fifo_q[wptr_q] <= bus.pred_taken;
   end

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= RUN;
         rec_cnt_q    <= '0;
         wptr_q       <= '0;
         rptr_q       <= '0;
         count_q      <= '0;
         spec_q       <= '0;
         arch_q       <= '0;
         mispredict_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         mispredict_q <= 1'b0;
         if (res_bad) err_q <= 1'b1;
         case (state_q)
            RUN: begin
               if (mis) begin
                  // Repair wins over a coincident accept: that entry is flushed too.
                  state_q      <= RECOVER;
                  rec_cnt_q    <= REC_LOAD;
                  mispredict_q <= 1'b1;
                  arch_q       <= shl(arch_q, bus.resolve_taken);
                  spec_q       <= shl(arch_q, bus.resolve_taken);
                  rptr_q       <= rptr_q + PTR_ONE;
                  wptr_q       <= rptr_q + PTR_ONE;
                  count_q      <= '0;
               end else begin
                  if (accept) begin
                     spec_q <= shl(spec_q, bus.pred_taken);
                     wptr_q <= wptr_q + PTR_ONE;
                  end
                  if (res_ok) begin
                     arch_q <= shl(arch_q, bus.resolve_taken);
                     rptr_q <= rptr_q + PTR_ONE;
                  end
                  case ({accept, res_ok})
                     2'b10:   count_q <= count_q + CNT_ONE;
                     2'b01:   count_q <= count_q - CNT_ONE;
                     default: count_q <= count_q;
                  endcase
               end
            end
            RECOVER: begin
               rec_cnt_q <= rec_cnt_q - REC_ONE;
               if (rec_cnt_q == REC_ONE) state_q <= RUN;
            end
            default: state_q <= RUN;
         endcase
      end
   end
endmodule

// File: tb/tb_ghr_spec_ctrl.sv
// Directed bench for ghr_spec_ctrl: fills, drains, wraps, repairs and resets the
// history controller against hand-computed values.
module tb_ghr_spec_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   ghr_spec_ctrl_if #(.HIST_W(12), .DEPTH(8)) bus ();

   ghr_spec_ctrl #(.HIST_W(12), .DEPTH(8), .RECOVER_CYCLES(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic pv, input logic pt, input logic rv, input logic rt);
      bus.pred_valid    = pv;
      bus.pred_taken    = pt;
      bus.resolve_valid = rv;
      bus.resolve_taken = rt;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [11:0] pat;
      logic [2:0]  exp_tag;
      logic [2:0]  b3;

      rst = 1'b1;
      drive(0, 0, 0, 0);
      #12;
      check("rst_spec", bus.spec_history, 0);
      check("rst_arch", bus.arch_history, 0);
      check("rst_inflight", bus.inflight, 0);
      check("rst_tag", bus.pred_tag, 0);
      check("rst_mispredict", bus.mispredict, 0);
      check("rst_recovering", bus.recovering, 0);
      check("rst_err", bus.err, 0);
      check("rst_ready", bus.pred_ready, 1);
      @(negedge clk);
      rst = 1'b0;

      // Accept taken, not-taken, taken.
      b3 = 3'b101;
      for (int i = 2; i >= 0; i--) begin
         drive(1, b3[i], 0, 0);
         step();
      end
      drive(0, 0, 0, 0);
      check("t1_spec", bus.spec_history, 12'h005);
      check("t1_arch", bus.arch_history, 0);
      check("t1_inflight", bus.inflight, 3);
      check("t1_tag", bus.pred_tag, 3);

      // Resolve all three correctly.
      for (int i = 2; i >= 0; i--) begin
         drive(0, 0, 1, b3[i]);
         step();
         check("t2_no_mispredict", bus.mispredict, 0);
      end
      drive(0, 0, 0, 0);
      check("t2_arch", bus.arch_history, 12'h005);
      check("t2_spec", bus.spec_history, 12'h005);
      check("t2_inflight", bus.inflight, 0);

      // Fill to DEPTH; tag runs 3..7 then wraps to 0.
      exp_tag = 3'd3;
      for (int i = 0; i < 8; i++) begin
         check("t3_tag_seq", bus.pred_tag, exp_tag);
         check("t3_ready_fill", bus.pred_ready, 1);
         drive(1, 1, 0, 0);
         step();
         exp_tag = exp_tag + 3'd1;
      end
      drive(0, 0, 0, 0);
      check("t3_full_inflight", bus.inflight, 8);
      check("t3_full_ready", bus.pred_ready, 0);
      check("t3_full_spec", bus.spec_history, 12'h5FF);
      check("t3_full_tag", bus.pred_tag, 3);
      drive(1, 0, 1, 1);
      step();
      drive(0, 0, 0, 0);
      check("t3_full_res_inflight", bus.inflight, 7);
      check("t3_full_res_arch", bus.arch_history, 12'h00B);
      check("t3_full_res_spec", bus.spec_history, 12'h5FF);
      check("t3_full_res_tag", bus.pred_tag, 3);
      for (int i = 0; i < 7; i++) begin
         drive(0, 0, 1, 1);
         step();
      end
      drive(0, 0, 0, 0);
      check("t3_drain_arch", bus.arch_history, 12'h5FF);
      check("t3_drain_inflight", bus.inflight, 0);

      // Load 0x0A5 into both histories with overlapping accept/resolve.
      pat = 12'h0A5;
      drive(1, pat[11], 0, 0);
      step();
      for (int k = 1; k < 12; k++) begin
         drive(1, pat[11-k], 1, pat[12-k]);
         step();
         check("t4_overlap_inflight", bus.inflight, 1);
      end
      drive(0, 0, 1, pat[0]);
      step();
      drive(0, 0, 0, 0);
      check("t4_load_arch", bus.arch_history, 12'h0A5);
      check("t4_load_spec", bus.spec_history, 12'h0A5);
      check("t4_load_inflight", bus.inflight, 0);
      check("t4_load_mispredict", bus.mispredict, 0);

      // Two taken predictions, first resolves not-taken.
      drive(1, 1, 0, 0);
      step();
      step();
      drive(0, 0, 0, 0);
      check("t4_pre_spec", bus.spec_history, 12'h297);
      check("t4_pre_inflight", bus.inflight, 2);
      drive(0, 0, 1, 0);
      step();
      drive(0, 0, 0, 0);
      check("t4_mis_pulse", bus.mispredict, 1);
      check("t4_mis_spec", bus.spec_history, 12'h14A);
      check("t4_mis_arch", bus.arch_history, 12'h14A);
      check("t4_mis_inflight", bus.inflight, 0);
      check("t4_mis_recovering", bus.recovering, 1);
      check("t4_stall1_ready", bus.pred_ready, 0);
      step();
      check("t4_pulse_end", bus.mispredict, 0);
      check("t4_stall2_ready", bus.pred_ready, 0);
      check("t4_stall2_recovering", bus.recovering, 1);
      step();
      check("t4_run_ready", bus.pred_ready, 1);
      check("t4_run_recovering", bus.recovering, 0);
      check("t4_run_tag", bus.pred_tag, 0);

      // Mispredicting resolve coincident with an accept.
      drive(1, 1, 0, 0);
      step();
      drive(0, 0, 0, 0);
      check("t5_pre_spec", bus.spec_history, 12'h295);
      check("t5_pre_inflight", bus.inflight, 1);
      drive(1, 1, 1, 0);
      step();
      drive(0, 0, 0, 0);
      check("t5_mis_pulse", bus.mispredict, 1);
      check("t5_spec", bus.spec_history, 12'h294);
      check("t5_arch", bus.arch_history, 12'h294);
      check("t5_inflight", bus.inflight, 0);
      step();
      step();
      check("t5_run_ready", bus.pred_ready, 1);

      // Resolve with an empty FIFO.
      drive(0, 0, 1, 1);
      step();
      drive(0, 0, 0, 0);
      check("t6_err", bus.err, 1);
      check("t6_arch", bus.arch_history, 12'h294);
      check("t6_spec", bus.spec_history, 12'h294);
      check("t6_inflight", bus.inflight, 0);
      check("t6_mispredict", bus.mispredict, 0);

      // Enter RECOVER, then reset asynchronously mid-recovery.
      drive(1, 1, 0, 0);
      step();
      drive(0, 0, 1, 0);
      step();
      drive(0, 0, 0, 0);
      check("t6_in_recover", bus.recovering, 1);
      #2 rst = 1'b1;
      #1;
      check("t6_arst_spec", bus.spec_history, 0);
      check("t6_arst_arch", bus.arch_history, 0);
      check("t6_arst_inflight", bus.inflight, 0);
      check("t6_arst_tag", bus.pred_tag, 0);
      check("t6_arst_mispredict", bus.mispredict, 0);
      check("t6_arst_recovering", bus.recovering, 0);
      check("t6_arst_err", bus.err, 0);
      check("t6_arst_ready", bus.pred_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      step();
      check("t6_post_recovering", bus.recovering, 0);
      check("t6_post_ready", bus.pred_ready, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
